// File: rtl/spi_xfer_ctrl.sv
// SPI master transaction controller: frames one DATA_WIDTH-bit transfer with chip select and a gated sclk divider.
// Optional macro SPI_LSB_FIRST_EN: shift LSB first in both directions (default MSB first).
module spi_xfer_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FREQ_CNT   = 1,
    parameter int unsigned CNT_WIDTH  = 1,
    parameter int unsigned CPOL       = 1,
    parameter int unsigned CPHA       = 0,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  miso,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n
);

    localparam logic        SCLK_IDLE = (CPOL != 0);
    localparam int unsigned LAST_EDGE = 2 * DATA_WIDTH;
    localparam int unsigned EDGE_W    = $clog2(LAST_EDGE + 1);
    localparam int unsigned PH_MAX    = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PH_W      = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [CNT_WIDTH-1:0]  div_q, div_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  out_bit, first_bit;
    logic [DATA_WIDTH-1:0] sh_in;
    logic [EDGE_W-1:0]     edge_nxt;
    logic                  lead, last;

`ifdef SPI_LSB_FIRST_EN
    assign out_bit   = sh_q[0];
    assign first_bit = tx_data[0];
    assign sh_in     = {miso, sh_q[DATA_WIDTH-1:1]};
`else
    assign out_bit   = sh_q[DATA_WIDTH-1];
    assign first_bit = tx_data[DATA_WIDTH-1];
    assign sh_in     = {sh_q[DATA_WIDTH-2:0], miso};
`endif

    assign edge_nxt = edge_q + EDGE_W'(1);
    assign lead     = edge_nxt[0];
    assign last     = (edge_nxt == EDGE_W'(LAST_EDGE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= SCLK_IDLE;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        div_d   = div_q;
        edge_d  = edge_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    ph_d    = '0;
                    sh_d    = tx_data;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = (CPHA == 0) ? first_bit : 1'b0;
                end
            end
            // The acceptance cycle plus CS_SETUP counted cycles precede divider enable.
            SETUP: begin
                if (ph_q == PH_W'(CS_SETUP)) begin
                    state_d = XFER;
                    ph_d    = '0;
                    div_d   = '0;
                    edge_d  = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            XFER: begin
                if (div_q == CNT_WIDTH'(FREQ_CNT)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (lead) begin
                        if (CPHA == 0) sh_d   = sh_in;
                        else           mosi_d = out_bit;
                    end else begin
                        if (CPHA != 0)  sh_d   = sh_in;
                        else if (!last) mosi_d = out_bit;
                    end
                    if (last) begin
                        state_d = HOLD;
                        edge_d  = '0;
                        ph_d    = '0;
                    end
                end else begin
                    div_d = div_q + CNT_WIDTH'(1);
                end
            end
            HOLD: begin
                if (ph_q == PH_W'(CS_HOLD - 1)) begin
                    state_d = IDLE;
                    ph_d    = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = sh_q;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: a CPHA=0 and a CPHA=1 instance, table-driven frames plus reset, abort and back-to-back sequences.
module tb_spi_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] tx0, tx1;
    logic       miso0, miso1;
    logic [1:0] mmode;
    logic       sel;

    logic       busy0, done0, sclk0, mosi0, cs_n0;
    logic       busy1, done1, sclk1, mosi1, cs_n1;
    logic [7:0] rx0, rx1;

    logic       cur_busy, cur_done, cur_sclk, cur_mosi, cur_cs_n;
    logic [7:0] cur_rx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // mmode: 0 loopback, 2 miso tied 0, 3 miso tied 1
    assign miso0 = (mmode == 2'd0) ? mosi0 : mmode[0];
    assign miso1 = (mmode == 2'd0) ? mosi1 : mmode[0];

    assign cur_busy = sel ? busy1 : busy0;
    assign cur_done = sel ? done1 : done0;
    assign cur_sclk = sel ? sclk1 : sclk0;
    assign cur_mosi = sel ? mosi1 : mosi0;
    assign cur_cs_n = sel ? cs_n1 : cs_n0;
    assign cur_rx   = sel ? rx1   : rx0;

    spi_xfer_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .miso(miso0),
        .busy(busy0), .done(done0), .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0)
    );

    spi_xfer_ctrl #(.CPHA(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .miso(miso1),
        .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic first_of(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v[0];
`else
        return v[7];
`endif
    endfunction

    typedef struct {
        bit         s;
        logic [7:0] tx;
        logic [1:0] mode;
        bit         viol;
        logic [7:0] exp_rx;
        logic       exp_first;
    } vec_t;

    vec_t vecs[8];

    logic       r_busy, r_csn, r_first, r_hp_ok, r_cs_ok;
    logic [7:0] r_rx, r_mw;
    int         r_lat, r_tog, r_dones;

    task automatic run_frame(input bit s, input logic [7:0] tx, input logic [1:0] mode, input bit viol);
        int   last_t;
        logic prev;
        bit   got_done;
        bit   vdone;
        sel = s; mmode = mode;
        if (s) begin tx1 = tx; start1 = 1'b1; end
        else   begin tx0 = tx; start0 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        r_busy = cur_busy; r_csn = cur_cs_n; r_first = cur_mosi;
        r_lat = -1; r_tog = 0; r_dones = 0; r_hp_ok = 1'b1; r_cs_ok = 1'b0;
        r_mw = '0; r_rx = '0; last_t = -1; prev = cur_sclk; got_done = 0; vdone = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (viol) begin
                if (r_tog == 4 && !vdone) begin
                    start0 = 1'b1; tx0 = 8'hFF; vdone = 1;
                end else begin
                    start0 = 1'b0;
                end
            end
            if (cur_sclk !== prev) begin
                if (last_t >= 0 && (c - last_t) != 2) r_hp_ok = 1'b0;
                last_t = c;
                r_tog++;
                if (prev == 1'b1) begin
`ifdef SPI_LSB_FIRST_EN
                    r_mw = {cur_mosi, r_mw[7:1]};
`else
                    r_mw = {r_mw[6:0], cur_mosi};
`endif
                end
                prev = cur_sclk;
            end
            if (cur_done) begin
                r_dones++;
                if (!got_done) begin
                    got_done = 1;
                    r_lat    = c;
                    r_rx     = cur_rx;
                    r_cs_ok  = cur_cs_n && !cur_busy;
                end
            end
            if (got_done && c >= r_lat + 4) break;
        end
        start0 = 1'b0;
    endtask

    initial begin
        int tog, t1, t2, ndone, hi_run, runs, bad_run;
        logic prev;
        bit seen_low;

        vecs[0] = '{0, 8'hA5, 2'd0, 0, 8'hA5, first_of(8'hA5)};
        vecs[1] = '{0, 8'h3C, 2'd0, 1, 8'h3C, first_of(8'h3C)};
        vecs[2] = '{1, 8'h96, 2'd3, 0, 8'hFF, 1'b0};
        vecs[3] = '{1, 8'h69, 2'd2, 0, 8'h00, 1'b0};
        vecs[4] = '{0, 8'h00, 2'd0, 0, 8'h00, first_of(8'h00)};
        vecs[5] = '{0, 8'hFF, 2'd2, 0, 8'h00, first_of(8'hFF)};
        vecs[6] = '{1, 8'hC3, 2'd0, 0, 8'hC3, 1'b0};
        vecs[7] = '{0, 8'h01, 2'd0, 0, 8'h01, first_of(8'h01)};

        sel = 0; mmode = 2'd0;
        rst = 1'b0; start0 = 1'b1; start1 = 1'b1; tx0 = 8'hAA; tx1 = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk0", sclk0, 1); chk("rst_csn0", cs_n0, 1); chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0); chk("rst_rx0", rx0, 0);   chk("rst_mosi0", mosi0, 0);
        chk("rst_sclk1", sclk1, 1); chk("rst_csn1", cs_n1, 1); chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0); chk("rst_rx1", rx1, 0);   chk("rst_mosi1", mosi1, 0);
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].s, vecs[i].tx, vecs[i].mode, vecs[i].viol);
            chk($sformatf("v%0d_busy", i),   r_busy,  1);
            chk($sformatf("v%0d_csn", i),    r_csn,   0);
            chk($sformatf("v%0d_first", i),  r_first, vecs[i].exp_first);
            chk($sformatf("v%0d_lat", i),    r_lat,   37);
            chk($sformatf("v%0d_dones", i),  r_dones, 1);
            chk($sformatf("v%0d_tog", i),    r_tog,   16);
            chk($sformatf("v%0d_hp", i),     r_hp_ok, 1);
            chk($sformatf("v%0d_csrise", i), r_cs_ok, 1);
            chk($sformatf("v%0d_rx", i),     r_rx,    vecs[i].exp_rx);
            chk($sformatf("v%0d_mosi", i),   r_mw,    vecs[i].tx);
        end

        // Abort after the fifth sclk edge
        sel = 0; mmode = 2'd0; tx0 = 8'h77; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        tog = 0; prev = sclk0;
        for (int c = 0; c < 100 && tog < 5; c++) begin
            @(posedge clk); #1;
            if (sclk0 !== prev) begin tog++; prev = sclk0; end
        end
        chk("abort_reached_edge5", tog, 5);
        #2 rst = 1'b0;
        #1;
        chk("abort_csn", cs_n0, 1); chk("abort_sclk", sclk0, 1); chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0); chk("abort_mosi", mosi0, 0);
        repeat (2) @(posedge clk);
        #1 chk("abort_no_done", done0, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 8'h5A, 2'd0, 0);
        chk("post_abort_lat", r_lat, 37);
        chk("post_abort_rx", r_rx, 8'h5A);
        chk("post_abort_dones", r_dones, 1);

        // Back-to-back with start held high
        sel = 0; mmode = 2'd0; tx0 = 8'h5A; start0 = 1'b1;
        t1 = -1; t2 = -1; ndone = 0; hi_run = 0; runs = 0; bad_run = 0; seen_low = 0;
        for (int c = 1; c <= 120 && ndone < 2; c++) begin
            @(posedge clk); #1;
            if (cs_n0 == 1'b0) begin
                if (seen_low && hi_run > 0) begin
                    runs++;
                    if (hi_run != 1) bad_run++;
                end
                hi_run = 0; seen_low = 1;
            end else if (seen_low) begin
                hi_run++;
            end
            if (done0) begin
                ndone++;
                if (ndone == 1) t1 = c;
                if (ndone == 2) t2 = c;
            end
        end
        start0 = 1'b0;
        chk("b2b_dones", ndone, 2);
        chk("b2b_gap", t2 - t1, 38);
        chk("b2b_cs_high_runs", runs, 1);
        chk("b2b_cs_high_len", bad_run, 0);
        chk("b2b_rx", rx0, 8'h5A);
        repeat (3) @(posedge clk);
        #1 chk("b2b_idle_after", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
